vliw_run_ctrl: RTL
==================

Name: vliw_run_ctrl

Overview:
Parametrised run controller for the VLIW core, replacing ad-hoc reset/run sequencing with a synthesizable block. It holds all execution lanes in reset for a programmable period, then releases them in a staggered order. It runs them for a bounded or unbounded number of cycles and stops on timeout or a lane halt request. It sits between the top-level clk/rst and the per-lane reset/enable inputs of the core, and reports cycle count and stop cause.

Parameters:
LANES, 4, number of execution lanes sequenced (>=1)
HOLD_CYCLES, 5, cycles all lanes are held in reset after start (>=1)
STAGGER, 1, cycles between successive lane reset releases (0 = all lanes together)
RUN_CYCLES, 3, run length before timeout; 0 = unlimited (must be < 2**CNT_W)
CNT_W, 16, width of run cycle counter

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin sequence; sampled only in IDLE or DONE
abort  in  1  return to IDLE from any state; lanes forced into reset
halt_req  in  LANES  per-lane halt request, sampled in RUN only
lane_rst_n  out  LANES  per-lane active-low reset to core lanes
lane_en  out  LANES  per-lane execute enable
state  out  3  current state (vliw_pkg::run_state_e)
cycle_cnt  out  CNT_W  RUN cycles elapsed, saturating
done  out  1  high while in DONE
cause  out  1  0 = timeout, 1 = halt; valid while done
halt_lane  out  $clog2(LANES) or 1  lowest halting lane index; valid while done and cause=1

Behaviour:
- Reset (rst=0, async): state=IDLE, lane_rst_n=0, lane_en=0, cycle_cnt=0, done=0, cause=0, halt_lane=0. All outputs are registered.
- IDLE: lanes are in reset. start=1 moves to HOLD on the next edge.
- HOLD: lasts exactly HOLD_CYCLES cycles. lane_rst_n=0 and cycle_cnt=0 throughout. Then moves to RELEASE.
- RELEASE: rc counts 0,1,.. from entry. lane_rst_n[i] rises on the edge ending the cycle where rc==i*STAGGER. RELEASE lasts (LANES-1)*STAGGER+1 cycles, then moves to RUN. Lane 0 rises first; lane LANES-1 is high in the first RUN cycle.
- RUN: lane_en all ones in every RUN cycle and only then. cycle_cnt=0 in the first RUN cycle and increments each RUN cycle, saturating at all ones.
- Timeout: with RUN_CYCLES!=0, the RUN cycle where cycle_cnt==RUN_CYCLES-1 moves to DONE with cause=0. RUN therefore lasts exactly RUN_CYCLES cycles.
- Halt: any halt_req bit set in a RUN cycle moves to DONE next edge with cause=1 and halt_lane = lowest set index. That cycle is still counted.
- Halt coincident with timeout: halt wins, cause=1.
- DONE: lane_en=0, lane_rst_n stays all ones, done=1, cycle_cnt frozen. start=1 moves to HOLD: lane_rst_n drops to 0 in the first HOLD cycle, cycle_cnt clears, done clears.
- start in HOLD/RELEASE/RUN is ignored.
- abort=1 in any state wins over start/halt/timeout. Next cycle: IDLE, lane_rst_n=0, lane_en=0, done=0; cycle_cnt retains its value.
- rst asserted mid-sequence: immediate reset values, with no glitch ordering requirement between lanes.
- RUN_CYCLES=0: RUN exits only via halt or abort. cycle_cnt saturates and does not wrap.

Decomposition:
- vliw_pkg: run_state_e enum {IDLE, HOLD, RELEASE, RUN, DONE}, stop_cause_e {CAUSE_TIMEOUT, CAUSE_HALT}, localparam CNT_W default.
- One sub-module: vliw_sat_counter (parametrised width, clear, enable, saturate).
  - Used for the hold, release and run counters.
- Lane release and priority encoder stay inline.

Test Plan:
- Defaults; start pulse sampled at edge 0 -> HOLD cycles 1-5; RELEASE cycles 6-9; lane_rst_n 4'b0001 at cycle 7, 4'b1111 at 10; RUN 10-12; DONE at 13, cycle_cnt=2, cause=0.
- STAGGER=0, LANES=2 -> lane_rst_n goes 2'b00 to 2'b11 in one step; RELEASE is 1 cycle.
- Defaults, RUN_CYCLES=0, halt_req=4'b0110 in 2nd RUN cycle -> DONE next cycle; cause=1, halt_lane=1, cycle_cnt=1.
- halt_req asserted in last RUN cycle (cycle_cnt=2) -> cause=1, not timeout; a halt_req during HOLD is ignored.
- abort in RELEASE after lane 1 is released -> next cycle IDLE, lane_rst_n=0; a subsequent start restarts a full HOLD of 5 cycles.
- CNT_W=2, RUN_CYCLES=0 -> cycle_cnt 0,1,2,3,3,3 with no wrap; rst low mid-RUN -> all outputs reset asynchronously, before the next edge.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared types for the VLIW run controller.
// State and stop-cause encodings seen on its outputs.
package vliw_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } run_state_e;

  typedef enum logic {
    CAUSE_TIMEOUT = 1'b0,
    CAUSE_HALT    = 1'b1
  } stop_cause_e;

endpackage

// File: rtl/vliw_sat_counter.sv
// Up-counter with synchronous clear that sticks at all ones.
// Clear has priority over enable.
module vliw_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/vliw_run_ctrl.sv
// Run controller: holds lanes in reset, releases them staggered,
// runs them for a bounded or unbounded time and reports why it stopped.
module vliw_run_ctrl
  import vliw_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int HOLD_CYCLES = 5,
  parameter int STAGGER     = 1,
  parameter int RUN_CYCLES  = 3,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LANES-1:0] halt_req,
  output logic [LANES-1:0] lane_rst_n,
  output logic [LANES-1:0] lane_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             cause,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] halt_lane
);

  localparam int HLW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int REL_END = (LANES - 1) * STAGGER;
  localparam int RCW = (REL_END > 0) ? $clog2(REL_END + 1) : 1;

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [RCW-1:0] REL_LAST  = RCW'(REL_END);
  localparam bit             TMO_EN    = (RUN_CYCLES != 0);
  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);

  run_state_e       r_state;
  stop_cause_e      r_cause;
  logic [LANES-1:0] r_lane_rst_n;
  logic [LANES-1:0] r_lane_en;
  logic             r_done;
  logic [HLW-1:0]   r_halt_lane;

  logic [HCW-1:0]   w_hold_cnt;
  logic [RCW-1:0]   w_rel_cnt;
  logic [CNT_W-1:0] w_run_cnt;
  logic [HLW-1:0]   w_pe;
  logic             w_start_ok;
  logic             w_hold_end;
  logic             w_rel_end;
  logic             w_halt;
  logic             w_tmo;

  assign w_start_ok = start &&
    ((r_state == IDLE) || (r_state == DONE));
  assign w_hold_end = (r_state == HOLD) &&
    (w_hold_cnt == HOLD_LAST);
  assign w_rel_end = (r_state == RELEASE) &&
    (w_rel_cnt == REL_LAST);
  assign w_halt = (r_state == RUN) && (|halt_req);
  assign w_tmo = TMO_EN && (r_state == RUN) &&
    (w_run_cnt == RUN_LAST);

  // Lowest requesting lane wins.
  always_comb begin
    w_pe = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (halt_req[i]) w_pe = HLW'(i);
    end
  end

  vliw_sat_counter #(.W(HCW)) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_start_ok),
    .i_en  (r_state == HOLD),
    .o_q   (w_hold_cnt)
  );

  vliw_sat_counter #(.W(RCW)) u_rel_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_hold_end),
    .i_en  (r_state == RELEASE),
    .o_q   (w_rel_cnt)
  );

  // Run count is frozen on the stopping edge and kept across abort.
  vliw_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_start_ok && !abort),
    .i_en  ((r_state == RUN) && !abort && !w_halt && !w_tmo),
    .o_q   (w_run_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_lane_rst_n <= '0;
      r_lane_en    <= '0;
      r_done       <= 1'b0;
      r_cause      <= CAUSE_TIMEOUT;
      r_halt_lane  <= '0;
    end else if (abort) begin
      r_state      <= IDLE;
      r_lane_rst_n <= '0;
      r_lane_en    <= '0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state      <= HOLD;
            r_lane_rst_n <= '0;
            r_done       <= 1'b0;
          end
        end
        HOLD: begin
          if (w_hold_end) r_state <= RELEASE;
        end
        RELEASE: begin
          for (int i = 0; i < LANES; i++) begin
            if (w_rel_cnt == RCW'(i * STAGGER))
              r_lane_rst_n[i] <= 1'b1;
          end
          if (w_rel_end) begin
            r_state   <= RUN;
            r_lane_en <= '1;
          end
        end
        RUN: begin
          if (w_halt) begin
            r_state     <= DONE;
            r_lane_en   <= '0;
            r_done      <= 1'b1;
            r_cause     <= CAUSE_HALT;
            r_halt_lane <= w_pe;
          end else if (w_tmo) begin
            r_state   <= DONE;
            r_lane_en <= '0;
            r_done    <= 1'b1;
            r_cause   <= CAUSE_TIMEOUT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state      = r_state;
  assign lane_rst_n = r_lane_rst_n;
  assign lane_en    = r_lane_en;
  assign cycle_cnt  = w_run_cnt;
  assign done       = r_done;
  assign cause      = r_cause;
  assign halt_lane  = r_halt_lane;

endmodule
